adsr_envelope: RTL and testbench

ADSR amplitude envelope stage between the waveform generator and the audio controller in the synth datapath. Scales each signed 32-bit sample by a 16-bit envelope level driven by a five-state ADSR state machine keyed by a note gate. Produces a write strobe gated by the controller's `audio_out_allowed`, so the controller's output FIFO is never overrun.

---
 rtl/adsr_envelope.sv | 140 ++++++++++++++
 tb/tb_adsr_envelope.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: a five-state envelope generator keyed by a note gate,
// scaling each signed sample through a two-stage free-running multiply pipeline.
module adsr_envelope #(
    parameter int TICK_DIV = 50000
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               gate,
    input  logic [7:0]         attack_rate,
    input  logic [7:0]         decay_rate,
    input  logic [7:0]         sustain_level,
    input  logic [7:0]         release_rate,
    input  logic signed [31:0] sample_in,
    input  logic               audio_out_allowed,
    output logic signed [31:0] sample_out,
    output logic               write_out,
    output logic [15:0]        env_level,
    output logic [2:0]         env_state
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t             state;
    logic [15:0]        level;
    logic [CNT_W-1:0]   tick_cnt;
    logic               tick;
    logic               gate_q;
    logic               rise;
    logic               fall;
    logic [15:0]        target;
    logic [15:0]        atk_step;
    logic [15:0]        dec_step;
    logic [15:0]        rel_step;
    logic [15:0]        atk_next;
    logic               dec_reach;
    logic               rel_reach;
    logic signed [48:0] prod_p1;
    logic signed [31:0] scaled_p2;
    logic               vld_p1;
    logic               vld_p2;

    function automatic logic [15:0] add_sat(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Arithmetic shift by 16 of the 49-bit product; bits above 47 are pure sign.
    function automatic logic signed [31:0] scale_floor(input logic signed [48:0] p);
        return $signed(p[47:16]);
    endfunction

    assign tick      = (tick_cnt == CNT_LAST);
    assign rise      = gate & ~gate_q;
    assign fall      = ~gate & gate_q;
    assign target    = {sustain_level, 8'h00};
    assign atk_step  = {attack_rate, 8'h00};
    assign dec_step  = {4'h0, decay_rate, 4'h0};
    assign rel_step  = {4'h0, release_rate, 4'h0};
    assign atk_next  = (attack_rate == 8'd0) ? 16'hFFFF : add_sat(level, atk_step);
    assign dec_reach = (decay_rate == 8'd0) ||
                       ({1'b0, level} <= ({1'b0, target} + {1'b0, dec_step}));
    assign rel_reach = (release_rate == 8'd0) || (level <= rel_step);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
            gate_q   <= 1'b0;
            state    <= IDLE;
            level    <= '0;
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            gate_q   <= gate;
            vld_p1   <= 1'b1;
            vld_p2   <= vld_p1;
            // Gate edges take priority over the envelope tick; level holds on an edge.
            if (rise) begin
                state <= ATTACK;
            end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
                state <= RELEASE;
            end else if (tick) begin
                case (state)
                    ATTACK: begin
                        level <= atk_next;
                        if (atk_next == 16'hFFFF) state <= DECAY;
                    end
                    DECAY: begin
                        if (dec_reach) begin
                            level <= target;
                            state <= SUSTAIN;
                        end else begin
                            level <= level - dec_step;
                        end
                    end
                    SUSTAIN: level <= target;
                    RELEASE: begin
                        if (rel_reach) begin
                            level <= '0;
                            state <= IDLE;
                        end else begin
                            level <= level - rel_step;
                        end
                    end
                    default: begin
                        level <= '0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Stage 1: full-precision product; stage 2: scaled sample.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            prod_p1   <= '0;
            scaled_p2 <= '0;
        end else begin
            prod_p1   <= sample_in * $signed({1'b0, level});
            scaled_p2 <= scale_floor(prod_p1);
        end
    end

    assign sample_out = scaled_p2;
    assign write_out  = audio_out_allowed & vld_p2;
    assign env_level  = level;
    assign env_state  = state;

endmodule

// File: tb/tb_adsr_envelope.sv
// Randomized bench for adsr_envelope, checked against an integer-arithmetic envelope model.
module tb_adsr_envelope;

    localparam int TDIV = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        gate = 1'b0;
    logic [7:0]  attack_rate = 8'd0;
    logic [7:0]  decay_rate = 8'd0;
    logic [7:0]  sustain_level = 8'd0;
    logic [7:0]  release_rate = 8'd0;
    logic [31:0] sample_in = 32'd0;
    logic        allowed = 1'b0;
    logic [31:0] sample_out;
    logic        write_out;
    logic [15:0] env_level;
    logic [2:0]  env_state;

    int checks = 0;
    int errors = 0;

    adsr_envelope #(.TICK_DIV(TDIV)) dut (
        .CLOCK_50(clk),
        .resetn(resetn),
        .gate(gate),
        .attack_rate(attack_rate),
        .decay_rate(decay_rate),
        .sustain_level(sustain_level),
        .release_rate(release_rate),
        .sample_in(sample_in),
        .audio_out_allowed(allowed),
        .sample_out(sample_out),
        .write_out(write_out),
        .env_level(env_level),
        .env_state(env_state)
    );

    always #5 clk = ~clk;

    // Reference model: states as plain ints (0 idle .. 4 release), levels as ints.
    int          m_level = 0;
    int          m_state = 0;
    int          m_cnt = 0;
    int          m_since = 0;
    bit          m_gq = 1'b0;
    bit [31:0]   e1 = 32'd0;
    bit [31:0]   e2 = 32'd0;
    int          n_level;
    int          n_state;
    int          n_v;
    int          m_t;
    bit          m_tick;
    bit          m_rise;
    bit          m_fall;

    function automatic bit [31:0] ref_scale(input logic [31:0] s, input int lvl);
        longint p;
        longint q;
        p = longint'($signed(s)) * longint'(lvl);
        q = p / 65536;
        if (p < 0 && q * 65536 != p) q = q - 1;
        return q[31:0];
    endfunction

    always_comb begin
        n_level = m_level;
        n_state = m_state;
        n_v     = 0;
        m_t     = int'(sustain_level) * 256;
        m_tick  = (m_cnt == TDIV - 1);
        m_rise  = gate && !m_gq;
        m_fall  = !gate && m_gq;
        if (m_rise) begin
            n_state = 1;
        end else if (m_fall && m_state >= 1 && m_state <= 3) begin
            n_state = 4;
        end else if (m_tick) begin
            case (m_state)
                1: begin
                    n_v = (attack_rate == 8'd0) ? 65535 : m_level + int'(attack_rate) * 256;
                    if (n_v > 65535) n_v = 65535;
                    n_level = n_v;
                    if (n_v == 65535) n_state = 2;
                end
                2: begin
                    n_v = m_level - int'(decay_rate) * 16;
                    if (decay_rate == 8'd0 || n_v <= m_t) begin
                        n_level = m_t;
                        n_state = 3;
                    end else begin
                        n_level = n_v;
                    end
                end
                3: n_level = m_t;
                4: begin
                    n_v = m_level - int'(release_rate) * 16;
                    if (release_rate == 8'd0 || n_v <= 0) begin
                        n_level = 0;
                        n_state = 0;
                    end else begin
                        n_level = n_v;
                    end
                end
                default: n_level = 0;
            endcase
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_level <= 0;
            m_state <= 0;
            m_cnt   <= 0;
            m_since <= 0;
            m_gq    <= 1'b0;
            e1      <= 32'd0;
            e2      <= 32'd0;
        end else begin
            m_level <= n_level;
            m_state <= n_state;
            m_cnt   <= (m_cnt == TDIV - 1) ? 0 : m_cnt + 1;
            m_gq    <= gate;
            e1      <= ref_scale(sample_in, m_level);
            e2      <= e1;
            if (m_since < 2) m_since <= m_since + 1;
        end
    end

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gate = 1'($urandom);
            attack_rate = 8'($urandom);
            decay_rate = 8'($urandom);
            sustain_level = 8'($urandom);
            release_rate = 8'($urandom);
            sample_in = $urandom;
            allowed = 1'($urandom);
            @(negedge clk);
            checks++;
            if (sample_out !== 32'd0 || env_level !== 16'd0 || env_state !== 3'd0 || write_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: out=%h lvl=%0d st=%0d wr=%b, required all 0",
                         sample_out, env_level, env_state, write_out);
            end
        end
        gate = 1'b0;
        allowed = 1'b1;
        sample_in = 32'd0;
        resetn = 1'b1;
        #1;
        checks++;
        if (write_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_prime_0: write_out=%b required 0", write_out);
        end
        @(negedge clk);
        checks++;
        if (write_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_prime_1: write_out=%b required 0", write_out);
        end
        @(negedge clk);
        checks++;
        if (write_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_prime_2: write_out=%b required 1", write_out);
        end
    endtask

    task automatic test_attack_decay();
        int att = 0;
        int dec = 0;
        int prev_l;
        int prev_s;
        bit done = 1'b0;
        attack_rate = 8'h10;
        decay_rate = 8'h20;
        sustain_level = 8'h80;
        release_rate = 8'h40;
        gate = 1'b1;
        prev_l = int'(env_level);
        prev_s = int'(env_state);
        for (int c = 0; c < 800 && !done; c++) begin
            @(negedge clk);
            checks++;
            if (env_level !== 16'(m_level) || env_state !== 3'(m_state) || sample_out !== e2) begin
                errors++;
                $display("FAIL ads_model: lvl=%0d/%0d st=%0d/%0d out=%h/%h",
                         env_level, m_level, env_state, m_state, sample_out, e2);
            end
            if (prev_s == 1 && int'(env_level) != prev_l) begin
                att++;
                checks++;
                if (!(int'(env_level) - prev_l == 4096 || env_level == 16'd65535)) begin
                    errors++;
                    $display("FAIL attack_step: level %0d -> %0d, required +4096 or 65535", prev_l, env_level);
                end
            end
            if (prev_s == 2 && int'(env_level) != prev_l) begin
                dec++;
                checks++;
                if (!(prev_l - int'(env_level) == 512 || env_level == 16'd32768)) begin
                    errors++;
                    $display("FAIL decay_step: level %0d -> %0d, required -512 or 32768", prev_l, env_level);
                end
            end
            if (prev_s == 1 && env_state == 3'd2) begin
                checks++;
                if (att != 16 || env_level !== 16'd65535) begin
                    errors++;
                    $display("FAIL attack_peak: ticks=%0d lvl=%0d, required 16 ticks and 65535", att, env_level);
                end
            end
            if (prev_s == 2 && env_state == 3'd3) begin
                checks++;
                done = 1'b1;
                if (dec != 64 || env_level !== 16'd32768) begin
                    errors++;
                    $display("FAIL decay_sustain: ticks=%0d lvl=%0d, required 64 ticks and 32768", dec, env_level);
                end
            end
            prev_l = int'(env_level);
            prev_s = int'(env_state);
            sample_in = $urandom;
        end
        if (!done) begin
            errors++;
            $display("FAIL ads_timeout: state=%0d required 3 within bound", env_state);
        end
    endtask

    task automatic test_scaling();
        logic [31:0] drv [6];
        logic [31:0] expv [6];
        drv[0] = 32'h0001_0000; expv[0] = 32'h0000_8000;
        drv[1] = 32'hFFFF_0000; expv[1] = 32'hFFFF_8000;
        drv[2] = 32'h0000_0001; expv[2] = 32'h0000_0000;
        for (int i = 3; i < 6; i++) begin
            drv[i] = $urandom;
            expv[i] = ref_scale(drv[i], 32768);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (sample_out !== expv[i-2] || env_level !== 16'd32768) begin
                    errors++;
                    $display("FAIL scale_%0d: in=%h out=%h required %h (lvl=%0d)",
                             i - 2, drv[i-2], sample_out, expv[i-2], env_level);
                end
            end
            if (i < 6) sample_in = drv[i];
        end
    endtask

    task automatic test_release_retrigger();
        int prev_l;
        int prev_s;
        int rel = 0;
        int lvl;
        bit done = 1'b0;
        release_rate = 8'h40;
        gate = 1'b0;
        prev_l = int'(env_level);
        prev_s = int'(env_state);
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            checks++;
            if (env_level !== 16'(m_level) || env_state !== 3'(m_state) || sample_out !== e2) begin
                errors++;
                $display("FAIL release_model: lvl=%0d/%0d st=%0d/%0d out=%h/%h",
                         env_level, m_level, env_state, m_state, sample_out, e2);
            end
            if (prev_s == 4 && int'(env_level) != prev_l) begin
                rel++;
                checks++;
                if (!(prev_l - int'(env_level) == 1024 || env_level == 16'd0)) begin
                    errors++;
                    $display("FAIL release_step: level %0d -> %0d, required -1024 or 0", prev_l, env_level);
                end
            end
            if (env_state == 3'd0 && prev_s == 4) done = 1'b1;
            prev_l = int'(env_level);
            prev_s = int'(env_state);
            sample_in = $urandom;
        end
        checks++;
        if (!done || rel != 32 || env_level !== 16'd0) begin
            errors++;
            $display("FAIL release_idle: done=%0d ticks=%0d lvl=%0d, required idle after 32 ticks at 0",
                     done, rel, env_level);
        end
        gate = 1'b1;
        for (int c = 0; c < 800 && env_state != 3'd3; c++) begin
            @(negedge clk);
            checks++;
            if (env_level !== 16'(m_level) || env_state !== 3'(m_state) || sample_out !== e2) begin
                errors++;
                $display("FAIL reattack_model: lvl=%0d/%0d st=%0d/%0d out=%h/%h",
                         env_level, m_level, env_state, m_state, sample_out, e2);
            end
        end
        gate = 1'b0;
        for (int c = 0; c < 600 && !(env_state == 3'd4 && env_level <= 16'd16384); c++) begin
            @(negedge clk);
        end
        lvl = int'(env_level);
        gate = 1'b1;
        @(negedge clk);
        checks++;
        if (env_state !== 3'd1 || int'(env_level) != lvl || lvl == 0) begin
            errors++;
            $display("FAIL retrigger: st=%0d lvl=%0d, required st 1 and lvl %0d (nonzero)", env_state, env_level, lvl);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (env_level !== 16'(m_level) || env_state !== 3'(m_state) || sample_out !== e2) begin
                errors++;
                $display("FAIL retrigger_model: lvl=%0d/%0d st=%0d/%0d", env_level, m_level, env_state, m_state);
            end
        end
        checks++;
        if (int'(env_level) <= lvl) begin
            errors++;
            $display("FAIL retrigger_rise: lvl=%0d required above %0d", env_level, lvl);
        end
    endtask

    task automatic test_collision_rate0();
        int lvl;
        bit hit = 1'b0;
        gate = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (env_state == 3'd4 && m_cnt == TDIV - 1) hit = 1'b1;
        end
        lvl = int'(env_level);
        gate = 1'b1;
        @(negedge clk);
        checks++;
        if (!hit || env_state !== 3'd1 || int'(env_level) != lvl) begin
            errors++;
            $display("FAIL collision: hit=%0d st=%0d lvl=%0d, required st 1 and lvl %0d", hit, env_state, env_level, lvl);
        end
        attack_rate = 8'd0;
        decay_rate = 8'd0;
        release_rate = 8'd0;
        sustain_level = 8'h5A;
        gate = 1'b0;
        for (int c = 0; c < 2 * TDIV + 2 && env_state != 3'd0; c++) @(negedge clk);
        checks++;
        if (env_state !== 3'd0 || env_level !== 16'd0) begin
            errors++;
            $display("FAIL rate0_release: st=%0d lvl=%0d, required 0 and 0", env_state, env_level);
        end
        gate = 1'b1;
        for (int c = 0; c < 2 * TDIV + 2 && env_level == 16'd0; c++) @(negedge clk);
        checks++;
        if (env_level !== 16'd65535 || env_state !== 3'd2) begin
            errors++;
            $display("FAIL rate0_attack: lvl=%0d st=%0d, required 65535 and 2", env_level, env_state);
        end
        for (int c = 0; c < 2 * TDIV + 2 && env_level == 16'd65535; c++) @(negedge clk);
        checks++;
        if (env_level !== 16'h5A00 || env_state !== 3'd3) begin
            errors++;
            $display("FAIL rate0_decay: lvl=%0d st=%0d, required 23040 and 3", env_level, env_state);
        end
    endtask

    task automatic test_reset_midnote();
        attack_rate = 8'h08;
        decay_rate = 8'h10;
        sustain_level = 8'h40;
        release_rate = 8'h20;
        gate = 1'b0;
        repeat (3) @(negedge clk);
        gate = 1'b1;
        allowed = 1'b1;
        repeat (30) begin
            @(negedge clk);
            sample_in = $urandom;
        end
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (sample_out !== 32'd0 || env_level !== 16'd0 || env_state !== 3'd0 || write_out !== 1'b0) begin
            errors++;
            $display("FAIL midnote_reset: out=%h lvl=%0d st=%0d wr=%b, required all 0",
                     sample_out, env_level, env_state, write_out);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (env_state !== 3'd1 || env_level !== 16'd0 || write_out !== 1'b0) begin
            errors++;
            $display("FAIL midnote_rise: st=%0d lvl=%0d wr=%b, required 1, 0, 0", env_state, env_level, write_out);
        end
    endtask

    task automatic test_random_backpressure();
        bit exp_w;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if (env_level !== 16'(m_level) || env_state !== 3'(m_state) || sample_out !== e2) begin
                errors++;
                $display("FAIL random_model: cyc=%0d lvl=%0d/%0d st=%0d/%0d out=%h/%h",
                         c, env_level, m_level, env_state, m_state, sample_out, e2);
            end
            allowed = 1'($urandom);
            if ($urandom_range(0, 29) == 0) gate = ~gate;
            if ($urandom_range(0, 199) == 0) begin
                attack_rate = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                decay_rate = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
                release_rate = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            end
            if ($urandom_range(0, 99) == 0) sustain_level = 8'($urandom);
            sample_in = $urandom;
            #1;
            exp_w = allowed && (m_since >= 2);
            checks++;
            if (write_out !== exp_w) begin
                errors++;
                $display("FAIL backpressure: cyc=%0d allowed=%b write_out=%b required %b", c, allowed, write_out, exp_w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_attack_decay();
        test_scaling();
        test_release_retrigger();
        test_collision_rate0();
        test_reset_midnote();
        test_random_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
